// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, majority-tap offsets, parity encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Majority taps sit around the nominal mid-bit point OVERSAMPLE/2.
  localparam int TAP_EARLY = -1;
  localparam int TAP_MID   = 0;
  localparam int TAP_LATE  = 1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counters and 3-tap majority vote; result resolved on the late tap, no backpressure.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int BCW        = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           clr_i,
  input  logic           rx_i,
  output logic           sampled_bit_o,
  output logic           sample_done_o,
  output logic           bit_done_o,
  output logic [BCW-1:0] bit_cnt_o
);

  localparam int ECW = $clog2(OVERSAMPLE);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(OVERSAMPLE - 1);
  localparam logic [ECW-1:0] TAP_LO    = ECW'(OVERSAMPLE / 2 + TAP_EARLY);
  localparam logic [ECW-1:0] TAP_CTR   = ECW'(OVERSAMPLE / 2 + TAP_MID);
  localparam logic [ECW-1:0] TAP_HI    = ECW'(OVERSAMPLE / 2 + TAP_LATE);

  logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           tap_lo_q, tap_lo_d;
  logic           tap_ctr_q, tap_ctr_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tap_lo_d   = tap_lo_q;
    tap_ctr_d  = tap_ctr_q;
    if (clr_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en_i) begin
      if (edge_cnt_q == EDGE_LAST) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BCW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + ECW'(1);
      end
      if (edge_cnt_q == TAP_LO)  tap_lo_d  = rx_i;
      if (edge_cnt_q == TAP_CTR) tap_ctr_d = rx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tap_lo_q   <= 1'b1;
      tap_ctr_q  <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tap_lo_q   <= tap_lo_d;
      tap_ctr_q  <= tap_ctr_d;
    end
  end

  // The third tap is the live input, so the vote resolves in the same cycle as the late sample.
  assign sampled_bit_o = majority3(tap_lo_q, tap_ctr_q, rx_i);
  assign sample_done_o = en_i && (edge_cnt_q == TAP_HI);
  assign bit_done_o    = en_i && (edge_cnt_q == EDGE_LAST);
  assign bit_cnt_o     = bit_cnt_q;

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: start/data/parity/stop framing, results registered at mid-stop; no backpressure.
// Optional UART_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module uart_rx_top
  import uart_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic             par_en,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             Data_Valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH + 3);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             par_flag_q, par_flag_d;
  logic             fpar_en_q, fpar_en_d;
  logic             fpar_typ_q, fpar_typ_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             se_q, se_d;

  logic             start_det;
  logic             smp_en;
  logic             go_idle;
  logic             exp_par;
  logic             sampled_bit;
  logic             sample_done;
  logic             bit_done;
  logic [BCW-1:0]   bit_cnt;

  assign start_det = (state_q == IDLE) && !rx_s;
  // The detect cycle counts as oversample 0 of the start bit.
  assign smp_en    = (state_q != IDLE) || start_det;
  assign exp_par   = (fpar_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .BCW        (BCW)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .en_i          (smp_en),
    .clr_i         (go_idle),
    .rx_i          (rx_s),
    .sampled_bit_o (sampled_bit),
    .sample_done_o (sample_done),
    .bit_done_o    (bit_done),
    .bit_cnt_o     (bit_cnt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    par_flag_d = par_flag_q;
    fpar_en_d  = fpar_en_q;
    fpar_typ_d = fpar_typ_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    go_idle    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          fpar_en_d  = par_en;
          fpar_typ_d = PAR_TYP;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (sample_done && sampled_bit) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end else if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_done) shift_d = {sampled_bit, shift_q[WIDTH-1:1]};
        if (bit_done && (bit_cnt == BCW'(WIDTH))) state_d = fpar_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (sample_done) par_flag_d = (sampled_bit != exp_par);
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (sample_done) begin
          state_d = IDLE;
          go_idle = 1'b1;
          if (!sampled_bit) begin
            se_d = 1'b1;
          end else if (par_flag_q) begin
            pe_d = 1'b1;
          end else begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        go_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pdata_q    <= '0;
      par_flag_q <= 1'b0;
      fpar_en_q  <= 1'b0;
      fpar_typ_q <= PAR_EVEN;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      par_flag_q <= par_flag_d;
      fpar_en_q  <= fpar_en_d;
      fpar_typ_q <= fpar_typ_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed frames against a frame-level model: each frame's outcome and pulse cycle come from its bits.
module tb_uart_rx_top;

  localparam int W  = 8;
  localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int K_DV = 0;
  localparam int K_PE = 1;
  localparam int K_SE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx = 1'b1;
  logic         pen = 1'b0;
  logic         ptyp = 1'b0;
  logic [W-1:0] p_data;
  logic         data_valid, par_err, stp_err, busy;

  uart_rx_top #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (rx),
    .par_en     (pen),
    .PAR_TYP    (ptyp),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] data;
  } ev_t;

  ev_t          evq[$];
  logic [W-1:0] m_pdata = '0;
  int           cyc = 0;
  logic         rst_smp = 1'b0;
  int           checks = 0;
  int           passed = 0;
  int           last_dv_cyc = -1;
  logic         edv, epe, ese;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_smp = rst;
  end

  // Per-cycle comparison of all pulse outputs and P_DATA against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      edv = 1'b0;
      epe = 1'b0;
      ese = 1'b0;
      if (!rst_smp) begin
        evq.delete();
        m_pdata = '0;
      end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
        case (evq[0].kind)
          K_DV: begin
            edv = 1'b1;
            m_pdata = evq[0].data;
          end
          K_PE: epe = 1'b1;
          default: ese = 1'b1;
        endcase
        void'(evq.pop_front());
      end
      if (data_valid === 1'b1) last_dv_cyc = cyc;
      check($sformatf("outputs@%0d {dv,pe,se,pdata}", cyc),
            {21'd0, data_valid, par_err, stp_err, p_data},
            {21'd0, edv, epe, ese, m_pdata});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; drives one frame one oversample at a time.
  task automatic send_frame(input logic [W-1:0] d, input logic pe_i, input logic typ_i,
                            input logic par_bad, input logic stop_v, input int flip_j,
                            input int abort_j, output int t_start);
    logic bits[$];
    logic par;
    ev_t  ev;
    int   nbits;
    par = (typ_i ? ~^d : ^d) ^ par_bad;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (pe_i) bits.push_back(par);
    bits.push_back(stop_v);
    nbits = bits.size();
    pen = pe_i;
    ptyp = typ_i;
    t_start = cyc;
    ev.cyc  = t_start + 1 + SYNC_LAT + (nbits - 1) * OS + OS / 2 + 1;
    ev.data = d;
    if (!stop_v)            ev.kind = K_SE;
    else if (pe_i && par_bad) ev.kind = K_PE;
    else                    ev.kind = K_DV;
    evq.push_back(ev);
    for (int j = 0; j < nbits * OS; j++) begin
      if (j == abort_j) begin
        rst = 1'b0;
        rx = 1'b1;
        idle(1);
        rst = 1'b1;
        return;
      end
      rx = bits[j / OS] ^ (j == flip_j);
      idle(1);
    end
    rx = 1'b1;
  endtask

  int t;
  int t2;

  initial begin
    rst = 1'b0;
    idle(3);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pdata", {24'd0, p_data}, 32'd0);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    rst = 1'b1;
    idle(5);

    // No parity, 0xA5: pulse (1+8)*8+4+1 = 77 cycles after the detect edge.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(20);
    check("lat_no_par", last_dv_cyc - t, 78 + SYNC_LAT);
    check("pdata_a5", {24'd0, p_data}, 32'h0000_00A5);
    check("busy_after_a5", {31'd0, busy}, 32'd0);

    // Even parity 0x3C (four ones, parity 0): 85-cycle latency.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(20);
    check("lat_par", last_dv_cyc - t, 86 + SYNC_LAT);
    check("pdata_3c", {24'd0, p_data}, 32'h0000_003C);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, t);
    idle(20);
    check("pdata_kept_par_err", {24'd0, p_data}, 32'h0000_003C);

    // Odd parity 0x01 (parity 0), then the same frame with a low stop bit.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1, t);
    idle(20);
    check("pdata_01", {24'd0, p_data}, 32'h0000_0001);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, t);
    idle(30);
    check("pdata_kept_stp_err", {24'd0, p_data}, 32'h0000_0001);
    check("busy_after_stp_err", {31'd0, busy}, 32'd0);

    // Two-cycle low glitch on the idle line.
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(1 + SYNC_LAT);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    idle(20);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);

    // One-cycle flip on the centre tap of data bit 2.
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 3 * OS + OS / 2, -1, t);
    idle(20);
    check("pdata_flip", {24'd0, p_data}, 32'h0000_0096);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t2);
    idle(20);
    check("b2b_spacing", last_dv_cyc - t2, 78 + SYNC_LAT);
    check("pdata_aa", {24'd0, p_data}, 32'h0000_00AA);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 5 * OS + 3, 5 * OS + 3, t);
    check("abort_pdata", {24'd0, p_data}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_flags", {29'd0, data_valid, par_err, stp_err}, 32'd0);
    idle(10);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, t);
    idle(20);
    check("pdata_0f", {24'd0, p_data}, 32'h0000_000F);

    check("events_drained", evq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
